// File: rtl/osd_spi_sched_pkg.sv
// Shared definitions for the OSD SPI scheduler: OSD command encodings,
// payload length limit, FSM state encoding and small command helpers.
package osd_spi_sched_pkg;

  localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
  localparam logic [7:0] OSD_LINE_MASK  = 8'h07;
  localparam logic [8:0] OSD_MAX_LEN    = 9'd256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DATA  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // Requested payload length saturated to what one OSD line accepts.
  function automatic logic [8:0] clamp_len(input logic [8:0] len);
    return (len > OSD_MAX_LEN) ? OSD_MAX_LEN : len;
  endfunction

  function automatic logic [7:0] osd_cmd_wr(input logic [2:0] line);
    return OSD_CMD_WRITE | ({5'd0, line} & OSD_LINE_MASK);
  endfunction

  function automatic logic [7:0] osd_cmd_en(input logic en);
    return OSD_CMD_ENABLE | {7'd0, en};
  endfunction

endpackage

// File: rtl/osd_spi_sched_if.sv
// Requester-side bus of the OSD SPI scheduler (two requesters, index k).
//   req_valid[k] / req_ready[k] : request handshake, ready is a 1-cycle grant
//   req_cmd[k], req_len[k]      : command byte and payload length (0..511)
//   dat_req[k] / dat_in[k]      : payload pull; byte valid the cycle after dat_req
// master = requesters, slave = scheduler.
interface osd_spi_sched_if;
  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_cmd;
  logic [1:0][8:0]  req_len;
  logic [1:0]       req_ready;
  logic [1:0]       dat_req;
  logic [1:0][7:0]  dat_in;

  modport master (output req_valid, req_cmd, req_len, dat_in,
                  input  req_ready, dat_req);
  modport slave  (input  req_valid, req_cmd, req_len, dat_in,
                  output req_ready, dat_req);
endinterface

// File: rtl/osd_spi_sched_shift.sv
// One-byte SPI mode-0 serialiser.
//   i_load/i_byte : start shifting a byte (DI = bit 7 the next cycle)
//   o_sck/o_di    : SPI clock (idle low) and data, MSB first
//   o_done        : high in the last SCK-high cycle of the byte, i.e. SCK
//                   falls and the shifter goes idle on the next edge
// Each bit: SCK low CLK_DIV cycles, then high CLK_DIV cycles; DI only
// changes on the edge where SCK goes low.
module osd_spi_sched_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sck,
  output logic       o_di,
  output logic       o_done
);
  logic        r_act;
  logic        r_sck;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_sh;
  logic        w_tick;

  assign w_tick = r_act && (r_cnt == 16'(CLK_DIV - 1));
  assign o_done = w_tick && r_sck && (r_bit == 3'd7);
  assign o_sck  = r_sck;
  assign o_di   = r_sh[7];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_act <= 1'b0;
      r_sck <= 1'b0;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else if (i_load) begin
      r_act <= 1'b1;
      r_sck <= 1'b0;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= i_byte;
    end else if (r_act) begin
      if (w_tick) begin
        r_cnt <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
        end else begin
          r_sck <= 1'b0;
          if (r_bit == 3'd7) begin
            // Last bit keeps DI as is; the top masks DI once SS3 rises.
            r_act <= 1'b0;
          end else begin
            r_bit <= r_bit + 3'd1;
            r_sh  <= {r_sh[6:0], 1'b0};
          end
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/osd_spi_sched.sv
// OSD SPI link scheduler: round-robin arbitration between two requesters,
// each grant serialised as one OSD transaction (command byte + 0..256
// payload bytes pulled through dat_req/dat_in).
//   clk_sys, reset_n : clock, async active-low reset
//   bus (slave)      : requester handshake and payload pull
//   busy, grant_id   : transaction in flight, current/last granted index
//   SPI_SCK/SS3/DI   : mode-0 SPI to the OSD receiver, SS3 active low
module osd_spi_sched
  import osd_spi_sched_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GUARD   = 4
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  osd_spi_sched_if.slave bus,
  output logic           busy,
  output logic           grant_id,
  output logic           SPI_SCK,
  output logic           SPI_SS3,
  output logic           SPI_DI
);
  state_t      r_state;
  logic        r_last;
  logic [7:0]  r_cmd;
  logic [8:0]  r_rem;
  logic [15:0] r_cnt;
  logic [1:0]  r_req_ready;
  logic [1:0]  r_dat_req;
  logic        r_busy;
  logic        r_gid;
  logic        r_ss3;

  logic        w_gnt;
  logic        w_k;
  logic        w_load;
  logic [7:0]  w_byte;
  logic        w_sck;
  logic        w_di;
  logic        w_done;

  // Round robin: on contention the requester not granted last wins.
  always_comb begin
    w_gnt = 1'b0;
    w_k   = 1'b0;
    case (bus.req_valid)
      2'b01:   begin w_gnt = 1'b1; w_k = 1'b0;    end
      2'b10:   begin w_gnt = 1'b1; w_k = 1'b1;    end
      2'b11:   begin w_gnt = 1'b1; w_k = ~r_last; end
      default: begin w_gnt = 1'b0; w_k = 1'b0;    end
    endcase
  end

  // Command loads on the grant cycle (SS3 still high); payload loads on the
  // second FETCH cycle, when dat_in answers the previous cycle's dat_req.
  assign w_load = ((r_state == ST_CMD) && r_ss3) ||
                  ((r_state == ST_FETCH) && (r_dat_req == 2'b00));
  assign w_byte = (r_state == ST_CMD) ? r_cmd : bus.dat_in[r_gid];

  osd_spi_sched_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_byte  (w_byte),
    .o_sck   (w_sck),
    .o_di    (w_di),
    .o_done  (w_done)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_cmd       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_dat_req   <= '0;
      r_busy      <= 1'b0;
      r_gid       <= 1'b0;
      r_ss3       <= 1'b1;
    end else begin
      r_req_ready <= '0;
      r_dat_req   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_req_ready <= w_k ? 2'b10 : 2'b01;
            r_gid       <= w_k;
            r_last      <= w_k;
            r_busy      <= 1'b1;
            r_cmd       <= bus.req_cmd[w_k];
            r_rem       <= clamp_len(bus.req_len[w_k]);
            r_state     <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA: begin
          if (r_ss3) begin
            r_ss3 <= 1'b0;
          end else if (w_done) begin
            if (r_rem != 9'd0) begin
              r_dat_req <= r_gid ? 2'b10 : 2'b01;
              r_rem     <= r_rem - 9'd1;
              r_state   <= ST_FETCH;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_TAIL;
            end
          end
        end
        ST_FETCH: begin
          if (r_dat_req == 2'b00) r_state <= ST_DATA;
        end
        ST_TAIL: begin
          if (r_cnt == 16'(CLK_DIV - 1)) begin
            r_cnt   <= '0;
            r_ss3   <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 16'(GUARD - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.dat_req   = r_dat_req;
  assign busy          = r_busy;
  assign grant_id      = r_gid;
  assign SPI_SCK       = w_sck;
  assign SPI_SS3       = r_ss3;
  assign SPI_DI        = r_ss3 ? 1'b0 : w_di;
endmodule

// File: tb/tb_osd_spi_sched.sv
module tb_osd_spi_sched;
  import osd_spi_sched_pkg::*;

  localparam int CD    = 4;
  localparam int GD    = 4;
  localparam int BOUND = 40000;

  logic clk_sys;
  logic reset_n;
  logic busy, grant_id, SPI_SCK, SPI_SS3, SPI_DI;

  osd_spi_sched_if bus();

  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] c0 = '0, c1 = '0;
  logic [8:0] l0 = '0, l1 = '0;
  logic [7:0] d0 = '0, d1 = '0;

  assign bus.req_valid = {v1, v0};
  assign bus.req_cmd   = {c1, c0};
  assign bus.req_len   = {l1, l0};
  assign bus.dat_in    = {d1, d0};

  osd_spi_sched #(.CLK_DIV(CD), .GUARD(GD)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .SPI_SCK  (SPI_SCK),
    .SPI_SS3  (SPI_SS3),
    .SPI_DI   (SPI_DI)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Payload source: requester 1 sends a running count, requester 0 a
  // scrambled count, both restarting at each grant.
  function automatic logic [7:0] pay(input bit k, input int j);
    return k ? 8'(j) : (8'hA5 ^ 8'(j));
  endfunction

  initial begin : responder
    int n0, n1;
    n0 = 0; n1 = 0;
    forever begin
      @(negedge clk_sys);
      if (bus.req_ready[0]) n0 = 0;
      if (bus.req_ready[1]) n1 = 0;
      if (bus.dat_req[0]) begin d0 = pay(1'b0, n0); n0++; end
      if (bus.dat_req[1]) begin d1 = pay(1'b1, n1); n1++; end
    end
  end

  // SPI receiver / OSD model: samples DI on SCK rise while SS3 low.
  int         dreq0 = 0, dreq1 = 0, sck_rises = 0, sck_bad = 0;
  int         min_gap = 32'h7fff_ffff;
  logic [7:0] rx_q[$];
  logic [7:0] osd_mem [0:2047];

  initial begin : monitor
    logic       sck_q;
    logic [7:0] sh, mcmd;
    int         bits, idx, hi;
    bit         seen_low;
    sck_q = 1'b0; sh = '0; mcmd = '0; bits = 0; idx = 0; hi = 0; seen_low = 0;
    forever begin
      @(negedge clk_sys);
      if (bus.dat_req[0]) dreq0++;
      if (bus.dat_req[1]) dreq1++;
      if (SPI_SS3 !== 1'b0) begin
        bits = 0; idx = 0; hi++;
        if (SPI_SCK) sck_bad++;
      end else begin
        if (hi > 0 && seen_low && hi < min_gap) min_gap = hi;
        hi = 0; seen_low = 1;
        if (SPI_SCK && !sck_q) begin
          sck_rises++;
          sh = {sh[6:0], SPI_DI};
          bits++;
          if (bits == 8) begin
            rx_q.push_back(sh);
            if (idx == 0) mcmd = sh;
            else if (mcmd[7:3] == 5'b00100 && idx <= 256)
              osd_mem[{mcmd[2:0], 8'(idx - 1)}] = sh;
            idx++;
            bits = 0;
          end
        end
      end
      sck_q = SPI_SCK;
    end
  end

  int         n_cmp = 0, n_err = 0, rd = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_rx(input string nm);
    logic [31:0] a;
    logic [7:0]  e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rd < rx_q.size()) ? {24'd0, rx_q[rd]} : 32'hDEAD;
      chk(nm, a, {24'd0, e});
      rd++;
    end
    chk({nm, "_count"}, rx_q.size(), rd);
  endtask

  task automatic run_txn(input bit k, input logic [7:0] cmd, input logic [8:0] len, input int n);
    int s0, s1, ss, cyc, t, g;
    exp_q.push_back(cmd);
    for (int j = 0; j < n; j++) exp_q.push_back(pay(k, j));
    s0 = dreq0; s1 = dreq1; ss = sck_rises;
    if (k) begin v1 = 1'b1; c1 = cmd; l1 = len; end
    else   begin v0 = 1'b1; c0 = cmd; l0 = len; end
    cyc = 0;
    do begin @(negedge clk_sys); cyc++; end while (!bus.req_ready[k] && cyc < BOUND);
    chk("grant_seen", 32'(bus.req_ready[k]), 1);
    chk("grant_id", 32'(grant_id), 32'(k));
    chk("busy_on_grant", 32'(busy), 1);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk_sys);
    chk("ss3_after_grant", 32'(SPI_SS3), 0);
    t = 1;
    while (!SPI_SS3 && t < BOUND) begin @(negedge clk_sys); t++; end
    chk("ss3_low_cycles", t - 1, 16*CD*(n+1) + 2*n + CD);
    g = 0;
    while (busy && g < BOUND) begin @(negedge clk_sys); g++; end
    chk("guard_cycles", g, GD);
    chk("sck_rises", sck_rises - ss, 8*(n+1));
    chk("dat_req_own", k ? (dreq1 - s1) : (dreq0 - s0), n);
    chk("dat_req_other", k ? (dreq0 - s0) : (dreq1 - s1), 0);
    check_rx("rx_byte");
  endtask

  typedef struct {
    bit         k;
    logic [7:0] cmd;
    logic [8:0] len;
    int         n;
  } vec_t;

  initial begin : main
    vec_t       vecs[5];
    int         order[4], gids[4];
    int         ng, cyc, s0, s1, bad;
    bit         pend0, pend1;
    logic [7:0] ca, cb, cc, cdd;

    vecs[0] = '{1'b0, 8'h41, 9'd0,   0};
    vecs[1] = '{1'b1, 8'h23, 9'd256, 256};
    vecs[2] = '{1'b0, 8'h21, 9'd300, 256};
    vecs[3] = '{1'b1, 8'h40, 9'd1,   1};
    vecs[4] = '{1'b0, 8'h25, 9'd5,   5};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_sck", 32'(SPI_SCK), 0);
    chk("rst_ss3", 32'(SPI_SS3), 1);
    chk("rst_di", 32'(SPI_DI), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_dat_req", 32'(bus.dat_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Simultaneous requests straight after reset, each re-asserting at once
    ca = osd_cmd_en(1'b0); cb = osd_cmd_wr(3'd1); cc = osd_cmd_en(1'b1); cdd = osd_cmd_wr(3'd2);
    exp_q.push_back(ca);  exp_q.push_back(pay(1'b0, 0));
    exp_q.push_back(cb);  exp_q.push_back(pay(1'b1, 0)); exp_q.push_back(pay(1'b1, 1));
    exp_q.push_back(cc);  for (int j = 0; j < 3; j++) exp_q.push_back(pay(1'b0, j));
    exp_q.push_back(cdd); exp_q.push_back(pay(1'b1, 0));
    s0 = dreq0; s1 = dreq1;
    v0 = 1'b1; c0 = ca; l0 = 9'd1;
    v1 = 1'b1; c1 = cb; l1 = 9'd2;
    ng = 0; cyc = 0; pend0 = 0; pend1 = 0;
    while (ng < 4 && cyc < BOUND) begin
      @(negedge clk_sys); cyc++;
      if (pend0) begin v0 = 1'b1; c0 = cc;  l0 = 9'd3; pend0 = 0; end
      if (pend1) begin v1 = 1'b1; c1 = cdd; l1 = 9'd1; pend1 = 0; end
      if (bus.req_ready[0] && ng < 4) begin
        order[ng] = 0; gids[ng] = 32'(grant_id); ng++; v0 = 1'b0;
        if (ng == 1) pend0 = 1;
      end
      if (bus.req_ready[1] && ng < 4) begin
        order[ng] = 1; gids[ng] = 32'(grant_id); ng++; v1 = 1'b0;
        if (ng == 2) pend1 = 1;
      end
    end
    chk("arb_grants", ng, 4);
    for (int i = 0; i < 4; i++) begin
      chk("arb_order", (i < ng) ? order[i] : -1, i % 2);
      chk("arb_grant_id", (i < ng) ? gids[i] : -1, i % 2);
    end
    cyc = 0;
    while (busy && cyc < BOUND) begin @(negedge clk_sys); cyc++; end
    chk("arb_idle", 32'(busy), 0);
    chk("arb_dat_req0", dreq0 - s0, 4);
    chk("arb_dat_req1", dreq1 - s1, 3);
    check_rx("arb_rx");
    chk("ss3_gap_min_ok", 32'(min_gap >= GD), 1);
    chk("sck_idle_high", sck_bad, 0);

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].k, vecs[i].cmd, vecs[i].len, vecs[i].n);
      if (vecs[i].cmd == 8'h23) begin
        bad = 0;
        for (int j = 0; j < 256; j++) if (osd_mem[768 + j] !== 8'(j)) bad++;
        chk("osd_line3_buf", bad, 0);
      end
      repeat (2) @(negedge clk_sys);
    end
    chk("ss3_gap_min_ok2", 32'(min_gap >= GD), 1);
    chk("sck_idle_high2", sck_bad, 0);

    // Reset in the middle of payload byte 100
    s0 = dreq0;
    v0 = 1'b1; c0 = 8'h22; l0 = 9'd150;
    cyc = 0;
    do begin @(negedge clk_sys); cyc++; end while (!bus.req_ready[0] && cyc < BOUND);
    v0 = 1'b0;
    cyc = 0;
    while ((dreq0 - s0) < 100 && cyc < BOUND) begin @(negedge clk_sys); cyc++; end
    chk("reach_byte100", 32'((dreq0 - s0) >= 100), 1);
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("abort_ss3", 32'(SPI_SS3), 1);
    chk("abort_sck", 32'(SPI_SCK), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dat_req", 32'(bus.dat_req), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    rd = rx_q.size();
    run_txn(1'b0, 8'h41, 9'd3, 3);
    chk("sck_idle_high3", sck_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
